// File: rtl/ram_scan_display.sv
// RAM with manual read/write, auto-scan readout and 7-segment decode of address and data.
// Defining RAM_SCAN_CLEAR_EN adds a sequential memory-clear mode driven by the CLEAR pulse.
module ram_scan_display #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int SCAN_DIV = 50000000
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              MODE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              WREN,
  input  logic              CLEAR,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [ADDR_W-1:0] CUR_ADDR,
  output logic              BUSY,
  output logic [13:0]       HEX_ADDR,
  output logic [13:0]       HEX_DIN,
  output logic [13:0]       HEX_DOUT
);
  // state     | meaning
  // ST_MANUAL | CUR_ADDR follows ADDRESS, WREN writes
  // ST_SCAN   | CUR_ADDR steps every SCAN_DIV clocks, writes blocked
  // ST_CLEAR  | zero one word per clock, BUSY high (RAM_SCAN_CLEAR_EN only)
  localparam int DEPTH = 2**ADDR_W;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
`ifdef RAM_SCAN_CLEAR_EN
  localparam logic [1:0] ST_CLEAR  = 2'd2;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

`ifdef RAM_SCAN_CLEAR_EN
  logic busy_q, busy_d;
`else
  logic unused_clear;
  assign unused_clear = CLEAR;
`endif

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    div_cnt_d  = div_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = ADDRESS;
    mem_wdata  = DATA_IN;
`ifdef RAM_SCAN_CLEAR_EN
    busy_d     = busy_q;
    if (CLEAR && (state_q != ST_CLEAR)) begin
      state_d    = ST_CLEAR;
      busy_d     = 1'b1;
      cur_addr_d = '0;
      div_cnt_d  = '0;
    end else if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cur_addr_q;
      mem_wdata = '0;
      if (cur_addr_q == ADDR_LAST) begin
        busy_d     = 1'b0;
        state_d    = MODE ? ST_SCAN : ST_MANUAL;
        cur_addr_d = MODE ? '0 : ADDRESS;
        div_cnt_d  = '0;
      end else begin
        cur_addr_d = cur_addr_q + 1'b1;
      end
    end else
`endif
    if (!MODE) begin
      state_d    = ST_MANUAL;
      cur_addr_d = ADDRESS;
      div_cnt_d  = '0;
      mem_we     = WREN;
    end else if (state_q != ST_SCAN) begin
      state_d    = ST_SCAN;
      cur_addr_d = '0;
      div_cnt_d  = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d  = '0;
      cur_addr_d = cur_addr_q + 1'b1;
    end else begin
      div_cnt_d  = div_cnt_q + 1'b1;
    end
    // DATA_OUT always shows the word at the new CUR_ADDR; forward a same-edge write
    if (mem_we && (mem_waddr == cur_addr_d)) begin
      data_out_d = mem_wdata;
    end else begin
      data_out_d = mem_q[cur_addr_d];
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= ST_MANUAL;
      cur_addr_q <= '0;
      div_cnt_q  <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      div_cnt_q  <= div_cnt_d;
      data_out_q <= data_out_d;
    end
  end

`ifdef RAM_SCAN_CLEAR_EN
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end
  assign BUSY = busy_q;
`else
  assign BUSY = 1'b0;
`endif

  // Storage is deliberately not reset; an aborted clear leaves it partially zeroed
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign DATA_OUT = data_out_q;
  assign CUR_ADDR = cur_addr_q;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0011000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [7:0] addr_ext, din_ext, dout_ext;
  logic [6:0] din_hi, dout_hi;

  assign addr_ext = 8'(cur_addr_q);
  assign din_ext  = 8'(DATA_IN);
  assign dout_ext = 8'(data_out_q);
  assign din_hi   = seg7(din_ext[7:4]);
  assign dout_hi  = seg7(dout_ext[7:4]);

  always_comb begin
    HEX_ADDR = {seg7(addr_ext[7:4]), seg7(addr_ext[3:0])};
    HEX_DIN  = {(DATA_W == 4) ? SEG_BLANK : din_hi, seg7(din_ext[3:0])};
    HEX_DOUT = {(DATA_W == 4) ? SEG_BLANK : dout_hi, seg7(dout_ext[3:0])};
  end

endmodule

// File: tb/tb_ram_scan_display.sv
// Directed bench for ram_scan_display: a 4-bit/8-word instance and an 8-bit/4-word instance.
// Clear scenarios run when RAM_SCAN_CLEAR_EN is defined; otherwise CLEAR must be inert.
module tb_ram_scan_display;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0] seg_tab [16];
  localparam logic [6:0] BLANK = 7'b1111111;

  // 4-bit data, 8 words, SCAN_DIV=2
  logic       mode = 1'b0, wren = 1'b0, clear = 1'b0;
  logic [2:0] address = '0;
  logic [3:0] data_in = '0;
  logic [3:0] data_out;
  logic [2:0] cur_addr;
  logic       busy;
  logic [13:0] hex_addr, hex_din, hex_dout;

  // 8-bit data, 4 words, SCAN_DIV=2
  logic       mode8 = 1'b0, wren8 = 1'b0, clear8 = 1'b0;
  logic [1:0] address8 = '0;
  logic [7:0] din8 = '0;
  logic [7:0] dout8;
  logic [1:0] cur8;
  logic       busy8;
  logic [13:0] hexa8, hexi8, hexo8;

  ram_scan_display #(.DATA_W(4), .ADDR_W(3), .SCAN_DIV(2)) dut (
    .CLK(clk), .RESETN(rst_n), .MODE(mode), .ADDRESS(address), .DATA_IN(data_in),
    .WREN(wren), .CLEAR(clear), .DATA_OUT(data_out), .CUR_ADDR(cur_addr), .BUSY(busy),
    .HEX_ADDR(hex_addr), .HEX_DIN(hex_din), .HEX_DOUT(hex_dout)
  );

  ram_scan_display #(.DATA_W(8), .ADDR_W(2), .SCAN_DIV(2)) dut8 (
    .CLK(clk), .RESETN(rst_n), .MODE(mode8), .ADDRESS(address8), .DATA_IN(din8),
    .WREN(wren8), .CLEAR(clear8), .DATA_OUT(dout8), .CUR_ADDR(cur8), .BUSY(busy8),
    .HEX_ADDR(hexa8), .HEX_DIN(hexi8), .HEX_DOUT(hexo8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (data_out !== 4'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", data_out); end
    checks++; if (cur_addr !== 3'd0) begin failures++; $display("FAIL reset_cur got=%h exp=0", cur_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (hex_dout !== {BLANK, 7'b1000000}) begin failures++; $display("FAIL reset_hex_dout got=%b exp=%b", hex_dout, {BLANK, 7'b1000000}); end
    checks++; if (hexo8 !== {7'b1000000, 7'b1000000}) begin failures++; $display("FAIL reset_hexo8 got=%b", hexo8); end
    rst_n = 1'b1;
    #1;
    checks++; if (hex_addr !== {7'b1000000, 7'b1000000}) begin failures++; $display("FAIL release_hex_addr got=%b", hex_addr); end
    checks++; if (data_out !== 4'h0 || cur_addr !== 3'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL release_state dout=%h cur=%h busy=%b exp 0/0/0", data_out, cur_addr, busy);
    end
    step();
  endtask

  task automatic test_write_read();
    mode = 1'b0; address = 3'd5; data_in = 4'hA; wren = 1'b1;
    step();
    checks++; if (data_out !== 4'hA || cur_addr !== 3'd5) begin failures++; $display("FAIL wr5_fwd dout=%h cur=%h exp A/5", data_out, cur_addr); end
    address = 3'd2; data_in = 4'h6;
    step();
    wren = 1'b0; address = 3'd5;
    checks++; if (data_out !== 4'h6) begin failures++; $display("FAIL latency_hold got=%h exp=6", data_out); end
    step();
    checks++; if (data_out !== 4'hA) begin failures++; $display("FAIL rd5 got=%h exp=A", data_out); end
    checks++; if (hex_dout !== {BLANK, 7'b0001000}) begin failures++; $display("FAIL rd5_hex_dout got=%b exp=%b", hex_dout, {BLANK, 7'b0001000}); end
    checks++; if (hex_addr !== {7'b1000000, 7'b0010010}) begin failures++; $display("FAIL rd5_hex_addr got=%b", hex_addr); end
    checks++; if (hex_din !== {BLANK, 7'b0000010}) begin failures++; $display("FAIL hex_din got=%b exp=%b", hex_din, {BLANK, 7'b0000010}); end
    address = 3'd2;
    step();
    checks++; if (data_out !== 4'h6) begin failures++; $display("FAIL rd2 got=%h exp=6", data_out); end
  endtask

  task automatic test_write_through();
    address = 3'd7; data_in = 4'hC; wren = 1'b1;
    step();
    data_in = 4'h3;
    step();
    checks++; if (data_out !== 4'h3) begin failures++; $display("FAIL wt7 got=%h exp=3", data_out); end
    wren = 1'b0;
    step();
    checks++; if (data_out !== 4'h3) begin failures++; $display("FAIL wt7_hold got=%h exp=3", data_out); end
  endtask

  task automatic fill(input logic [3:0] base);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i); data_in = 4'(i) + base; wren = 1'b1;
      step();
    end
    wren = 1'b0;
  endtask

  task automatic test_fill_readback();
    fill(4'd1);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      step();
      checks++; if (data_out !== 4'(i + 1)) begin failures++; $display("FAIL readback a=%0d got=%h exp=%h", i, data_out, 4'(i + 1)); end
    end
    checks++; if (hex_addr !== {7'b1000000, seg_tab[7]}) begin failures++; $display("FAIL readback_hex_addr got=%b", hex_addr); end
  endtask

  task automatic test_scan();
    logic [7:0] mem8 [4];
    logic [1:0] exp_seq [9];
    mem8[0] = 8'hA5; mem8[1] = 8'h3C; mem8[2] = 8'h7E; mem8[3] = 8'h01;
    exp_seq[0] = 2'd0; exp_seq[1] = 2'd0; exp_seq[2] = 2'd1; exp_seq[3] = 2'd1; exp_seq[4] = 2'd2;
    exp_seq[5] = 2'd2; exp_seq[6] = 2'd3; exp_seq[7] = 2'd3; exp_seq[8] = 2'd0;
    for (int i = 0; i < 4; i++) begin
      mode8 = 1'b0; address8 = 2'(i); din8 = mem8[i]; wren8 = 1'b1;
      step();
    end
    address8 = 2'd3; din8 = 8'hFF; wren8 = 1'b1; mode8 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++; if (cur8 !== exp_seq[k] || dout8 !== mem8[exp_seq[k]]) begin
        failures++; $display("FAIL scan_step k=%0d cur=%0d dout=%h exp cur=%0d dout=%h", k, cur8, dout8, exp_seq[k], mem8[exp_seq[k]]);
      end
    end
    checks++; if (hexo8 !== {seg_tab[10], seg_tab[5]}) begin failures++; $display("FAIL scan_hexo8 got=%b exp=%b", hexo8, {seg_tab[10], seg_tab[5]}); end
    checks++; if (hexi8 !== {seg_tab[15], seg_tab[15]}) begin failures++; $display("FAIL scan_hexi8 got=%b", hexi8); end
    mode8 = 1'b0; wren8 = 1'b0; address8 = 2'd2;
    step();
    checks++; if (cur8 !== 2'd2 || dout8 !== 8'h7E) begin failures++; $display("FAIL scan_exit cur=%0d dout=%h exp 2/7e", cur8, dout8); end
    checks++; if (hexa8 !== {seg_tab[0], seg_tab[2]}) begin failures++; $display("FAIL scan_exit_hexa8 got=%b", hexa8); end
    for (int i = 0; i < 4; i++) begin
      address8 = 2'(i);
      step();
      checks++; if (dout8 !== mem8[i]) begin failures++; $display("FAIL scan_nowrite a=%0d got=%h exp=%h", i, dout8, mem8[i]); end
    end
  endtask

`ifdef RAM_SCAN_CLEAR_EN
  task automatic test_clear();
    int n;
    int k;
    mode = 1'b0; address = 3'd3; data_in = 4'hF; wren = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0; wren = 1'b0;
    checks++; if (busy !== 1'b1 || cur_addr !== 3'd0) begin failures++; $display("FAIL clear_start busy=%b cur=%0d exp 1/0", busy, cur_addr); end
    n = 1; k = 0;
    while (busy === 1'b1 && k < 20) begin
      step();
      k++;
      if (busy === 1'b1) begin
        n++;
        checks++; if (cur_addr !== 3'(k)) begin failures++; $display("FAIL clear_track k=%0d got=%0d", k, cur_addr); end
      end
    end
    checks++; if (n !== 8) begin failures++; $display("FAIL clear_busy_len got=%0d exp=8", n); end
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      step();
      checks++; if (data_out !== 4'h0) begin failures++; $display("FAIL clear_zero a=%0d got=%h exp=0", i, data_out); end
    end
  endtask

  task automatic test_clear_reset();
    fill(4'd8);
    clear = 1'b1;
    step();
    clear = 1'b0;
    step(); step(); step();
    checks++; if (busy !== 1'b1 || cur_addr !== 3'd3) begin failures++; $display("FAIL abort_pre busy=%b cur=%0d exp 1/3", busy, cur_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || cur_addr !== 3'd0 || data_out !== 4'h0) begin
      failures++; $display("FAIL abort_reset busy=%b cur=%0d dout=%h exp 0/0/0", busy, cur_addr, data_out);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      step();
      checks++; if (data_out !== ((i < 3) ? 4'h0 : 4'(i + 8))) begin
        failures++; $display("FAIL abort_mem a=%0d got=%h exp=%h", i, data_out, (i < 3) ? 4'h0 : 4'(i + 8));
      end
    end
  endtask
`else
  task automatic test_clear_disabled();
    mode = 1'b0; address = 3'd3; data_in = 4'hF; wren = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0; wren = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL noclear_busy got=%b exp=0", busy); end
    checks++; if (data_out !== 4'hF || cur_addr !== 3'd3) begin failures++; $display("FAIL noclear_write dout=%h cur=%0d exp F/3", data_out, cur_addr); end
    address = 3'd4;
    step();
    checks++; if (busy !== 1'b0 || data_out !== 4'h5) begin failures++; $display("FAIL noclear_after busy=%b dout=%h exp 0/5", busy, data_out); end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010; seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0011000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    test_reset();
    test_write_read();
    test_write_through();
    test_fill_readback();
    test_scan();
`ifdef RAM_SCAN_CLEAR_EN
    test_clear();
    test_clear_reset();
`else
    test_clear_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_scan_display.md
RAM_SCAN_DISPLAY -- requirements
Module: ram_scan_display

Interface
REQ-001 SHALL have parameter DATA_W, default 4: word width, legal values 4 or 8.
REQ-002 SHALL have parameter ADDR_W, default 5: address width, legal range 1..8; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter SCAN_DIV, default 50000000: clocks per scan step, minimum 1.
REQ-004 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port RESETN  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port MODE  input  1  0 = manual, 1 = auto-scan.
REQ-007 SHALL have port ADDRESS  input  ADDR_W  manual-mode address.
REQ-008 SHALL have port DATA_IN  input  DATA_W  write data.
REQ-009 SHALL have port WREN  input  1  write enable, manual mode only.
REQ-010 SHALL have port CLEAR  input  1  single-cycle pulse that starts a memory clear (REQ-030).
REQ-011 SHALL have port DATA_OUT  output  DATA_W  registered read data.
REQ-012 SHALL have port CUR_ADDR  output  ADDR_W  address currently read.
REQ-013 SHALL have port BUSY  output  1  high while a clear is in progress.
REQ-014 SHALL have ports HEX_ADDR, HEX_DIN, HEX_DOUT  output  14 each  two active-low 7-segment digits (gfedcba) per bus, low digit in [6:0].

Function
REQ-015 SHALL hold DEPTH words of DATA_W bits in synchronous single-port storage; contents are not reset.
REQ-016 SHALL implement states MANUAL, SCAN, CLEAR; MANUAL when MODE=0, SCAN when MODE=1, CLEAR entered only per REQ-030.
REQ-017 MANUAL: CUR_ADDR SHALL follow ADDRESS registered at each edge; when WREN=1, DATA_IN SHALL be written to ADDRESS on that edge.
REQ-018 Read latency SHALL be one clock: DATA_OUT equals the word at the address presented at the previous edge.
REQ-019 A read and write to the same address on one edge SHALL be write-through: DATA_OUT shows the new DATA_IN on the next cycle.
REQ-020 On entering SCAN, the scan address SHALL be 0 and the divider counter SHALL be 0.
REQ-021 SCAN: CUR_ADDR SHALL increment by 1 every SCAN_DIV clocks and wrap from DEPTH-1 to 0.
REQ-022 SCAN: WREN SHALL be ignored; no write occurs.
REQ-023 Leaving SCAN for MANUAL SHALL take effect on the next edge, with CUR_ADDR taken from ADDRESS.
REQ-024 Each nibble SHALL encode as 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000 8:0000000 9:0011000 A:0001000 b:0000011 C:1000110 d:0100001 E:0000110 F:0001110.
REQ-025 HEX_ADDR SHALL show CUR_ADDR, zero-extended to 8 bits.
REQ-026 HEX_DIN SHALL show DATA_IN and HEX_DOUT SHALL show DATA_OUT.
REQ-027 When DATA_W=4, the high digit of HEX_DIN and HEX_DOUT SHALL be blank (1111111).
REQ-028 All HEX outputs SHALL be combinational decodes of their registered sources.

Reset
REQ-029 While RESETN=0, the following SHALL hold:
- DATA_OUT, CUR_ADDR, the scan counters and BUSY all 0;
- state MANUAL;
- HEX_ADDR shows 00 and HEX_DOUT shows 0, with its high digit blank when DATA_W=4.
Reset during a clear SHALL abort it and leave contents partially cleared.

Configuration
REQ-030 With macro RAM_SCAN_CLEAR_EN defined, a CLEAR pulse in any state SHALL:
- enter CLEAR and set BUSY=1;
- write 0 to addresses 0..DEPTH-1, one per clock, with CUR_ADDR tracking the clear address;
- after the last write, deassert BUSY and return to the state selected by MODE.
REQ-031 During CLEAR, WREN, ADDRESS and further CLEAR pulses SHALL be ignored; CLEAR with WREN on the same edge SHALL drop the write.
REQ-032 Without RAM_SCAN_CLEAR_EN, the CLEAR input SHALL be ignored, BUSY SHALL be tied to 0, and the CLEAR state SHALL not exist.

Verification
REQ-033 Reset then release -> DATA_OUT=0, CUR_ADDR=0, HEX_ADDR={1000000,1000000}, BUSY=0.
REQ-034 Manual mode, write 4'hA at address 5, then read address 5 -> DATA_OUT=A one clock after the read, HEX_DOUT low digit=0001000.
REQ-035 Manual mode, same-edge write 4'h3 and read at address 7 -> next cycle DATA_OUT=3.
REQ-036 SCAN_DIV=2, ADDR_W=2, MODE=1 -> CUR_ADDR sequence 0,0,1,1,2,2,3,3,0; WREN=1 with DATA_IN=F in SCAN -> contents unchanged.
REQ-037 With RAM_SCAN_CLEAR_EN and ADDR_W=3, after filling memory with nonzero data, pulse CLEAR with WREN=1 -> BUSY high for exactly 8 clocks, and all addresses then read 0.
REQ-038 RESETN asserted at clear cycle 3 -> BUSY=0 immediately, addresses 0..2 read 0, and higher addresses keep their old data.
